// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the SRAM slave: response codes,
// channel FSM state encodings and latency-counter sizing.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Latency minus one can reach 15 + 15 - 1, so five bits are needed
  localparam int         LAT_W       = 5;
  localparam logic [7:0] LFSR_SEED   = 8'hA5;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/lat_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) producing the response
// latency minus one, shared by the read and write channel FSMs.
module lat_lfsr
  import axi_lite_pkg::*;
#(
  parameter int         MIN_LAT  = 1,
  parameter logic [3:0] LAT_MASK = 4'h3
) (
  input  logic             clk,
  input  logic             rst,
  output logic [LAT_W-1:0] lat_m1
);

  logic [7:0] lfsr_reg;
  logic [7:0] lfsr_next;

  always_comb begin
    lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  // Counter preload value: the FSM spends lat_m1 extra cycles in its wait state
  assign lat_m1 = LAT_W'(MIN_LAT - 1) + LAT_W'(lfsr_reg[3:0] & LAT_MASK);

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave backed by a word-addressed on-chip SRAM, with independent
// read/write channel FSMs and programmable, optionally randomised latency.
module axi_lite_sram
  import axi_lite_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 16,
  parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
  parameter int                MIN_LAT    = 1,
  parameter logic [3:0]        LAT_MASK   = 4'h3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LANES = DATA_W / 8;

  rd_state_t r_state_reg, r_state_next;
  wr_state_t w_state_reg, w_state_next;

  logic [LAT_W-1:0]  lat_m1;
  logic [LAT_W-1:0]  r_cnt_reg;
  logic [LAT_W-1:0]  w_cnt_reg;
  logic [ADDR_W-1:0] r_addr_reg;
  logic [ADDR_W-1:0] aw_addr_reg;
  logic [DATA_W-1:0] w_data_reg;
  logic [LANES-1:0]  w_strb_reg;
  logic              aw_got_reg;
  logic              w_got_reg;
  logic [1:0]        rresp_reg;
  logic [1:0]        bresp_reg;

  logic                  ar_hs, aw_hs, w_hs;
  logic                  w_start, r_done, w_done, mem_we;
  logic [ADDR_W-1:0]     r_off, w_off;
  logic                  r_in_range, w_in_range;
  logic [DEPTH_LOG2-1:0] r_idx, w_idx;

  lat_lfsr #(
    .MIN_LAT  (MIN_LAT),
    .LAT_MASK (LAT_MASK)
  ) u_lat_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lat_m1 (lat_m1)
  );

  // Address decode: offset from BASE, low two bits ignored
  assign r_off      = r_addr_reg - BASE;
  assign w_off      = aw_addr_reg - BASE;
  assign r_in_range = (r_addr_reg >= BASE) && (r_off[ADDR_W-1:DEPTH_LOG2+2] == '0);
  assign w_in_range = (aw_addr_reg >= BASE) && (w_off[ADDR_W-1:DEPTH_LOG2+2] == '0);
  assign r_idx      = r_off[DEPTH_LOG2+1:2];
  assign w_idx      = w_off[DEPTH_LOG2+1:2];

  assign ar_hs   = arvalid && arready;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign w_start = (w_state_reg == W_IDLE) && (aw_got_reg || aw_hs) && (w_got_reg || w_hs);
  assign r_done  = (r_state_reg == R_WAIT) && (r_cnt_reg == '0);
  assign w_done  = (w_state_reg == W_WAIT) && (w_cnt_reg == '0);
  // Reset on the commit edge aborts the write
  assign mem_we  = w_done && w_in_range && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      w_state_reg <= W_IDLE;
    end else begin
      r_state_reg <= r_state_next;
      w_state_reg <= w_state_next;
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_WAIT;
      R_WAIT:  if (r_cnt_reg == '0) r_state_next = R_RESP;
      R_RESP:  if (rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (w_start) w_state_next = W_WAIT;
      W_WAIT:  if (w_cnt_reg == '0) w_state_next = W_RESP;
      W_RESP:  if (bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state_reg == R_IDLE);
    rvalid  = (r_state_reg == R_RESP);
    awready = (w_state_reg == W_IDLE) && !aw_got_reg;
    wready  = (w_state_reg == W_IDLE) && !w_got_reg;
    bvalid  = (w_state_reg == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_reg  <= '0;
      r_addr_reg <= '0;
      rresp_reg  <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        r_addr_reg <= araddr;
        r_cnt_reg  <= lat_m1;
      end else if ((r_state_reg == R_WAIT) && (r_cnt_reg != '0)) begin
        r_cnt_reg <= r_cnt_reg - LAT_W'(1);
      end
      if (r_done) begin
        rresp_reg <= r_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // AW and W are captured independently; the wait starts once both are held
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_got_reg  <= 1'b0;
      w_got_reg   <= 1'b0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      w_cnt_reg   <= '0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_addr_reg <= awaddr;
        aw_got_reg  <= 1'b1;
      end
      if (w_hs) begin
        w_data_reg <= wdata;
        w_strb_reg <= wstrb[LANES-1:0];
        w_got_reg  <= 1'b1;
      end
      if (w_start) begin
        w_cnt_reg <= lat_m1;
      end else if ((w_state_reg == W_WAIT) && (w_cnt_reg != '0)) begin
        w_cnt_reg <= w_cnt_reg - LAT_W'(1);
      end
      if (w_done) begin
        bresp_reg <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if ((w_state_reg == W_RESP) && bready) begin
        aw_got_reg <= 1'b0;
        w_got_reg  <= 1'b0;
      end
    end
  end

  // One byte-wide RAM per lane; a read sampled on the commit edge sees old data
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] lane_mem [0:DEPTH-1];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge clk) begin
      if (mem_we && w_strb_reg[gi]) begin
        lane_mem[w_idx] <= w_data_reg[8*gi +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_byte_reg <= 8'h00;
      end else if (r_done) begin
        rd_byte_reg <= r_in_range ? lane_mem[r_idx] : 8'h00;
      end
    end

    assign rdata[8*gi +: 8] = rd_byte_reg;
  end

  assign rresp = rresp_reg;
  assign bresp = bresp_reg;

  logic unused_bits;
  assign unused_bits = ^{wstrb[7:LANES], r_off[1:0], w_off[1:0]};

endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed and scoreboarded bench: instance 0 runs at fixed latency 1,
// instance 1 uses full LFSR randomisation with a mid-transaction reset.
`timescale 1ns/1ps
module tb_axi_lite_sram;
  import axi_lite_pkg::*;

  localparam logic [31:0] WIN = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst     [2];
  logic [31:0] araddr  [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [31:0] awaddr  [2];
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] wdata   [2];
  logic [7:0]  wstrb   [2];
  logic        wvalid  [2];
  logic        wready  [2];
  logic [1:0]  bresp   [2];
  logic        bvalid  [2];
  logic        bready  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    axi_lite_sram #(
      .MIN_LAT  (1),
      .LAT_MASK (gi == 0 ? 4'h0 : 4'hF)
    ) u_dut (
      .clk     (clk),
      .rst     (rst[gi]),
      .araddr  (araddr[gi]),
      .arvalid (arvalid[gi]),
      .arready (arready[gi]),
      .rdata   (rdata[gi]),
      .rresp   (rresp[gi]),
      .rvalid  (rvalid[gi]),
      .rready  (rready[gi]),
      .awaddr  (awaddr[gi]),
      .awvalid (awvalid[gi]),
      .awready (awready[gi]),
      .wdata   (wdata[gi]),
      .wstrb   (wstrb[gi]),
      .wvalid  (wvalid[gi]),
      .wready  (wready[gi]),
      .bresp   (bresp[gi]),
      .bvalid  (bvalid[gi]),
      .bready  (bready[gi])
    );
  end

  typedef struct {
    bit          do_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_b;
    logic [31:0] exp_rd;
    logic [1:0]  exp_r;
  } vec_t;

  vec_t vecs [9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input int d);
    check("reset_outputs",
          {arready[d], awready[d], wready[d], rvalid[d], bvalid[d], rdata[d], rresp[d], bresp[d]},
          {5'b11100, 32'h0, 2'b00, 2'b00});
  endtask

  task automatic axi_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                           input logic [7:0] strb, input int aw_dly, input int w_dly,
                           input int bstall, output logic [1:0] resp, output int lat);
    int t;
    int acc;
    bit aw_done, w_done, hs_aw, hs_w;
    t = 0; aw_done = 0; w_done = 0;
    awaddr[d] = addr; wdata[d] = data; wstrb[d] = strb;
    while (!(aw_done && w_done)) begin
      awvalid[d] = (t >= aw_dly) && !aw_done;
      wvalid[d]  = (t >= w_dly) && !w_done;
      hs_aw = awvalid[d] && awready[d];
      hs_w  = wvalid[d] && wready[d];
      if (aw_done != w_done)
        check("w_split_ready", {awready[d], wready[d]}, {!aw_done, !w_done});
      tick; t++;
      aw_done |= hs_aw;
      w_done  |= hs_w;
      if (t > 64) begin
        check("w_accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    acc = t;
    while (!bvalid[d] && (t - acc) < 40) begin
      tick; t++;
    end
    lat  = t - acc;
    resp = bresp[d];
    for (int i = 0; i < bstall; i++) begin
      check("b_hold", {bvalid[d], awready[d], wready[d], bresp[d]}, {3'b100, resp});
      tick;
    end
    bready[d] = 1'b1;
    tick;
    bready[d] = 1'b0;
    check("b_release", {awready[d], wready[d], bvalid[d]}, 3'b110);
    $display("dut%0d wr addr=%h data=%h strb=%h bresp=%0d lat=%0d", d, addr, data, strb, resp, lat);
  endtask

  task automatic axi_read(input int d, input logic [31:0] addr, input int ar_dly, input int rstall,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
    int t;
    int acc;
    bit done, hs;
    t = 0; done = 0;
    araddr[d] = addr;
    while (!done) begin
      arvalid[d] = (t >= ar_dly);
      hs = arvalid[d] && arready[d];
      tick; t++;
      done = hs;
      if (t > 64) begin
        check("r_accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    arvalid[d] = 1'b0;
    acc = t;
    while (!rvalid[d] && (t - acc) < 40) begin
      tick; t++;
    end
    lat  = t - acc;
    data = rdata[d];
    resp = rresp[d];
    for (int i = 0; i < rstall; i++) begin
      check("r_hold", {rvalid[d], arready[d], rresp[d], rdata[d]}, {2'b10, resp, data});
      tick;
    end
    rready[d] = 1'b1;
    tick;
    rready[d] = 1'b0;
    check("r_release", {arready[d], rvalid[d]}, 2'b10);
    $display("dut%0d rd addr=%h rdata=%h rresp=%0d lat=%0d", d, addr, data, resp, lat);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, data, addr, old;
    logic [1:0]  resp;
    logic [7:0]  strb;
    logic [31:0] sb [16];
    int          lat, idx;
    bit          oor, is_wr;

    vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, RESP_OKAY,   32'hDEAD_BEEF, RESP_OKAY};
    vecs[1] = '{1'b1, 32'h8000_0010, 32'h0000_1200, 8'h02, RESP_OKAY,   32'hDEAD_12EF, RESP_OKAY};
    vecs[2] = '{1'b1, 32'h8000_0013, 32'hAA00_0000, 8'hF8, RESP_OKAY,   32'hAAAD_12EF, RESP_OKAY};
    vecs[3] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'h00, RESP_OKAY,   32'hAAAD_12EF, RESP_OKAY};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h1122_3344, 8'h0F, RESP_OKAY,   32'h1122_3344, RESP_OKAY};
    vecs[5] = '{1'b1, 32'h8004_0000, 32'h1234_5678, 8'h0F, RESP_SLVERR, 32'h0000_0000, RESP_SLVERR};
    vecs[6] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 8'h00, RESP_OKAY,   32'h1122_3344, RESP_OKAY};
    vecs[7] = '{1'b1, 32'h7FFF_FFFC, 32'h5555_AAAA, 8'h0F, RESP_SLVERR, 32'h0000_0000, RESP_SLVERR};
    vecs[8] = '{1'b1, 32'h8003_FFFC, 32'h0BAD_F00D, 8'h0F, RESP_OKAY,   32'h0BAD_F00D, RESP_OKAY};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
      awaddr[d] = '0; awvalid[d] = 1'b0; wdata[d] = '0; wstrb[d] = '0;
      wvalid[d] = 1'b0; bready[d] = 1'b0;
    end
    repeat (3) tick;
    rst[0] = 1'b0; rst[1] = 1'b0;
    check_reset(0);
    check_reset(1);

    // Fixed-latency vector table
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].do_wr) begin
        axi_write(0, vecs[v].addr, vecs[v].data, vecs[v].strb, 0, 0, 0, resp, lat);
        check("vec_bresp", resp, vecs[v].exp_b);
        check("vec_wlat", lat, 1);
      end
      axi_read(0, vecs[v].addr, 0, 0, rd, resp, lat);
      check("vec_rdata", rd, vecs[v].exp_rd);
      check("vec_rresp", resp, vecs[v].exp_r);
      check("vec_rlat", lat, 1);
    end

    // W leads AW by three cycles, then AW leads W
    axi_write(0, 32'h8000_0030, 32'hCAFE_F00D, 8'h0F, 3, 0, 0, resp, lat);
    check("w_first_lat", lat, 1);
    check("w_first_bresp", resp, RESP_OKAY);
    axi_write(0, 32'h8000_0034, 32'h600D_CAFE, 8'h0F, 0, 3, 2, resp, lat);
    check("aw_first_lat", lat, 1);
    axi_read(0, 32'h8000_0030, 0, 0, rd, resp, lat);
    check("w_first_data", rd, 32'hCAFE_F00D);
    axi_read(0, 32'h8000_0034, 0, 0, rd, resp, lat);
    check("aw_first_data", rd, 32'h600D_CAFE);

    // Read-side backpressure for five cycles
    axi_read(0, 32'h8000_0010, 0, 5, rd, resp, lat);
    check("bp_rdata", rd, 32'hAAAD_12EF);
    check("bp_rresp", resp, RESP_OKAY);

    // Read and write commit on the same edge, then read one cycle later
    axi_write(0, 32'h8000_0020, 32'h0101_0101, 8'h0F, 0, 0, 0, resp, lat);
    fork
      axi_write(0, 32'h8000_0020, 32'h0202_0202, 8'h0F, 0, 0, 0, resp, lat);
      axi_read(0, 32'h8000_0020, 0, 0, rd, old, idx);
    join
    check("same_cycle_old", rd, 32'h0101_0101);
    fork
      axi_write(0, 32'h8000_0020, 32'h0303_0303, 8'h0F, 0, 0, 0, resp, lat);
      axi_read(0, 32'h8000_0020, 1, 0, rd, old, idx);
    join
    check("later_cycle_new", rd, 32'h0303_0303);

    // Randomised latency with scoreboard
    for (int i = 0; i < 16; i++) begin
      data  = $urandom;
      sb[i] = data;
      axi_write(1, WIN + 32'(i * 4), data, 8'h0F, 0, 0, 0, resp, lat);
      check("rnd_init_bresp", resp, RESP_OKAY);
    end
    for (int n = 0; n < 200; n++) begin
      idx   = $urandom_range(0, 15);
      oor   = ($urandom_range(0, 9) == 0);
      is_wr = $urandom_range(0, 1);
      addr  = (oor ? 32'h8004_0000 : WIN) + 32'(idx * 4) + 32'($urandom_range(0, 3));
      if (is_wr) begin
        data = $urandom;
        strb = 8'($urandom);
        axi_write(1, addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), resp, lat);
        check("rnd_bresp", resp, oor ? RESP_SLVERR : RESP_OKAY);
        check("rnd_wlat_range", (lat >= 1 && lat <= 16), 1'b1);
        if (!oor)
          for (int b = 0; b < 4; b++)
            if (strb[b]) sb[idx][8*b +: 8] = data[8*b +: 8];
      end else begin
        axi_read(1, addr, $urandom_range(0, 3), $urandom_range(0, 3), rd, resp, lat);
        check("rnd_rdata", rd, oor ? 32'h0 : sb[idx]);
        check("rnd_rresp", resp, oor ? RESP_SLVERR : RESP_OKAY);
        check("rnd_rlat_range", (lat >= 1 && lat <= 16), 1'b1);
      end

      if (n == 100) begin
        // Accept a read and a write together, then reset before either completes
        old = sb[5];
        araddr[1] = WIN + 32'd20; awaddr[1] = WIN + 32'd20;
        wdata[1] = ~old; wstrb[1] = 8'h0F;
        check("rst_accept_ready", {arready[1], awready[1], wready[1]}, 3'b111);
        arvalid[1] = 1'b1; awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        tick;
        arvalid[1] = 1'b0; awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        rst[1] = 1'b1;
        tick;
        rst[1] = 1'b0;
        check_reset(1);
        $display("dut1 rst pulse during wait addr=%h", WIN + 32'd20);
        axi_read(1, WIN + 32'd20, 0, 0, rd, resp, lat);
        check("rst_write_aborted", rd, old);
        check("rst_post_lat_range", (lat >= 1 && lat <= 16), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
